fifo_link_tx: RTL

//  Credit-based link transmitter on the read side of a router input fifo.
//  - Pops flits from a local fifo and drives them onto a point-to-point NoC link.
//  - The far end of the link is another fifo; its free slots are tracked with credits.
//  - Sits between a port fifo and the link toward a neighbouring router or PE.

---
 rtl/fifo_link_tx_if.sv | 29 ++
 rtl/fifo_link_tx.sv | 79 +++++++
 2 files changed

// File: rtl/fifo_link_tx_if.sv
// Link-side bundle of the credit-based transmitter: local fifo read port,
// outgoing flit link, credit return and status.
interface fifo_link_tx_if #(
    parameter int DATA_WIDTH   = 8,
    parameter int CREDIT_WIDTH = 2
);
    logic                    en_i;
    logic                    fifo_empty_i;
    logic                    fifo_rd_en_o;
    logic [DATA_WIDTH-1:0]   fifo_data_i;
    logic                    link_valid_o;
    logic [DATA_WIDTH-1:0]   link_data_o;
    logic                    credit_i;
    logic [CREDIT_WIDTH-1:0] credit_cnt_o;
    logic                    idle_o;
    logic                    credit_err_o;

    // Handshake: link_valid_o is a one-cycle pulse per flit with no ready;
    // each credit_i pulse returns exactly one downstream slot.
    modport master (
        input  en_i, fifo_empty_i, fifo_data_i, credit_i,
        output fifo_rd_en_o, link_valid_o, link_data_o, credit_cnt_o, idle_o, credit_err_o
    );

    modport slave (
        output en_i, fifo_empty_i, fifo_data_i, credit_i,
        input  fifo_rd_en_o, link_valid_o, link_data_o, credit_cnt_o, idle_o, credit_err_o
    );
endinterface

// File: rtl/fifo_link_tx.sv
// Credit-based NoC link transmitter: pops flits from a local fifo and forwards
// them onto the link only while the downstream fifo has credited free slots.
module fifo_link_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CREDIT_WIDTH = 2,
    parameter int CREDITS_INIT = 3
) (
    input  logic           clk_i,
    input  logic           rst_i,
    fifo_link_tx_if.master link
);
    localparam logic [CREDIT_WIDTH-1:0] CRED_MAX = CREDIT_WIDTH'(CREDITS_INIT);
    localparam logic [CREDIT_WIDTH-1:0] CRED_ONE = CREDIT_WIDTH'(1);

    logic                    rd_en;
    logic                    credit_full;
    logic                    rd_pend_q,    rd_pend_d;
    logic                    link_valid_q, link_valid_d;
    logic [DATA_WIDTH-1:0]   link_data_q,  link_data_d;
    logic [CREDIT_WIDTH-1:0] credit_cnt_q, credit_cnt_d;
    logic                    credit_err_q, credit_err_d;

    assign credit_full = (credit_cnt_q == CRED_MAX);

    // A credit arriving this cycle is not usable until the next one.
    assign rd_en = link.en_i & ~link.fifo_empty_i & (credit_cnt_q != '0) & ~rst_i;

    always_comb begin
        rd_pend_d    = rd_en;
        link_valid_d = rd_pend_q;
        link_data_d  = rd_pend_q ? link.fifo_data_i : link_data_q;
    end

    always_comb begin
        credit_cnt_d = credit_cnt_q;
        credit_err_d = credit_err_q;
        if (rd_en && !link.credit_i) begin
            credit_cnt_d = credit_cnt_q - CRED_ONE;
        end else if (!rd_en && link.credit_i) begin
            // A credit with nothing outstanding means the receiver miscounted.
            if (credit_full) begin
                credit_err_d = 1'b1;
            end else begin
                credit_cnt_d = credit_cnt_q + CRED_ONE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_pend_q    <= 1'b0;
            link_valid_q <= 1'b0;
            link_data_q  <= '0;
            credit_cnt_q <= CRED_MAX;
            credit_err_q <= 1'b0;
        end else begin
            rd_pend_q    <= rd_pend_d;
            link_valid_q <= link_valid_d;
            link_data_q  <= link_data_d;
            credit_cnt_q <= credit_cnt_d;
            credit_err_q <= credit_err_d;
        end
    end

    assign link.fifo_rd_en_o = rd_en;
    assign link.link_valid_o = link_valid_q;
    assign link.link_data_o  = link_data_q;
    assign link.credit_cnt_o = credit_cnt_q;
    assign link.credit_err_o = credit_err_q;
    assign link.idle_o       = ~rd_pend_q & ~link_valid_q & credit_full;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (credit_cnt_q <= CRED_MAX);
            assert (!rd_en || !link.fifo_empty_i);
            assert (!rd_en || credit_cnt_q != '0);
        end
    end
endmodule
